// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a pending scoreboard.
//
// The register file sits between decode and execute. Writes land on the rising
// edge, and reads are registered with one cycle of latency. A read sees the writes
// from the same edge (write-first bypass). A per-register pending bit marks
// registers that still wait for a result.
//
// Ports:
//   clk_i       clock; all state updates on the rising edge
//   rst_i       asynchronous, active-high reset
//   wr_en_i     write enable per write port
//   wr_addr_i   write address per port; port w at [w*NUM_ADDR_BITS +: NUM_ADDR_BITS]
//   wr_data_i   write data per port; port w at [w*REG_WIDTH +: REG_WIDTH]
//   rd_en_i     read enable per read port; when low, that port's outputs hold
//   rd_addr_i   read address per port
//   rd_data_o   registered read data per port
//   rd_pend_o   registered pending flag of the register that was read
//   rsv_en_i    reserve request: marks rsv_addr_i pending
//   rsv_addr_i  register to reserve
//   pend_vec_o  live pending bit per register, driven straight from the flops
module regfile_mp #(
    parameter int unsigned NUM_ADDR_BITS = 6,
    parameter int unsigned REG_WIDTH     = 32,
    parameter int unsigned NUM_RD        = 3,
    parameter int unsigned NUM_WR        = 2,
    parameter bit          ZERO_REG      = 1'b1,
    localparam int unsigned NUM_REGS     = 1 << NUM_ADDR_BITS
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_WR-1:0]               wr_en_i,
    input  logic [NUM_WR*NUM_ADDR_BITS-1:0] wr_addr_i,
    input  logic [NUM_WR*REG_WIDTH-1:0]     wr_data_i,
    input  logic [NUM_RD-1:0]               rd_en_i,
    input  logic [NUM_RD*NUM_ADDR_BITS-1:0] rd_addr_i,
    output logic [NUM_RD*REG_WIDTH-1:0]     rd_data_o,
    output logic [NUM_RD-1:0]               rd_pend_o,
    input  logic                            rsv_en_i,
    input  logic [NUM_ADDR_BITS-1:0]        rsv_addr_i,
    output logic [NUM_REGS-1:0]             pend_vec_o
);

    typedef logic [REG_WIDTH-1:0]     word_t;
    typedef logic [NUM_ADDR_BITS-1:0] addr_t;

    word_t               mem_q     [NUM_REGS];
    word_t               mem_d     [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;
    word_t               rd_data_q [NUM_RD];
    word_t               rd_data_d [NUM_RD];
    logic [NUM_RD-1:0]   rd_pend_q;
    logic [NUM_RD-1:0]   rd_pend_d;

    function automatic logic is_zero_reg(addr_t a);
        return ZERO_REG && (a == '0);
    endfunction

    // Post-edge register and scoreboard state.
    // Port order gives port 1 priority on an address collision.
    // The reserve is applied after the clears, so it wins over a write.
    always_comb begin : write_next
        mem_d  = mem_q;
        pend_d = pend_q;
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w]) begin
                if (!is_zero_reg(addr_t'(wr_addr_i[w*NUM_ADDR_BITS +: NUM_ADDR_BITS]))) begin
                    mem_d[wr_addr_i[w*NUM_ADDR_BITS +: NUM_ADDR_BITS]] =
                        wr_data_i[w*REG_WIDTH +: REG_WIDTH];
                end
                pend_d[wr_addr_i[w*NUM_ADDR_BITS +: NUM_ADDR_BITS]] = 1'b0;
            end
        end
        if (rsv_en_i) begin
            pend_d[rsv_addr_i] = 1'b1;
        end
        if (ZERO_REG) begin
            pend_d[0] = 1'b0;
        end
    end

    // Reading the next-state arrays gives the write-first bypass.
    always_comb begin : read_next
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            rd_data_d[p] = rd_data_q[p];
            rd_pend_d[p] = rd_pend_q[p];
            if (rd_en_i[p]) begin
                if (is_zero_reg(addr_t'(rd_addr_i[p*NUM_ADDR_BITS +: NUM_ADDR_BITS]))) begin
                    rd_data_d[p] = '0;
                    rd_pend_d[p] = 1'b0;
                end else begin
                    rd_data_d[p] = mem_d[rd_addr_i[p*NUM_ADDR_BITS +: NUM_ADDR_BITS]];
                    rd_pend_d[p] = pend_d[rd_addr_i[p*NUM_ADDR_BITS +: NUM_ADDR_BITS]];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                mem_q[r] <= '0;
            end
            for (int unsigned p = 0; p < NUM_RD; p++) begin
                rd_data_q[p] <= '0;
            end
            pend_q    <= '0;
            rd_pend_q <= '0;
        end else begin
            mem_q     <= mem_d;
            pend_q    <= pend_d;
            rd_data_q <= rd_data_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    always_comb begin : outputs
        rd_data_o = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            rd_data_o[p*REG_WIDTH +: REG_WIDTH] = rd_data_q[p];
        end
        rd_pend_o  = rd_pend_q;
        pend_vec_o = pend_q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized bench for regfile_mp.
// A behavioural model holds the register contents and the pending bits as plain
// arrays. Every cycle the bench compares the read ports and pend_vec with it.
module tb_regfile_mp;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int NR    = 3;
    localparam int NW    = 2;
    localparam int NREGS = 64;

    logic                clk = 1'b0;
    logic                rst;
    logic [NW-1:0]       wr_en;
    logic [NW*AW-1:0]    wr_addr;
    logic [NW*DW-1:0]    wr_data;
    logic [NR-1:0]       rd_en;
    logic [NR*AW-1:0]    rd_addr;
    logic [NR*DW-1:0]    rd_data;
    logic [NR-1:0]       rd_pend;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic [NREGS-1:0]    pend_vec;

    // Behavioural model
    logic [DW-1:0] m_mem [NREGS];
    bit            m_pend [NREGS];
    logic [DW-1:0] m_rd [NR];
    bit            m_rdp [NR];

    int checks   = 0;
    int failures = 0;

    regfile_mp #(
        .NUM_ADDR_BITS(AW),
        .REG_WIDTH    (DW),
        .NUM_RD       (NR),
        .NUM_WR       (NW),
        .ZERO_REG     (1'b1)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data),
        .rd_pend_o (rd_pend),
        .rsv_en_i  (rsv_en),
        .rsv_addr_i(rsv_addr),
        .pend_vec_o(pend_vec)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_en    = '0;
        rd_addr  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
    endtask

    task automatic set_wr(input int w, input int a, input logic [DW-1:0] d);
        wr_en[w]             = 1'b1;
        wr_addr[w*AW +: AW]  = AW'(a);
        wr_data[w*DW +: DW]  = d;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_en[p]            = 1'b1;
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_rsv(input int a);
        rsv_en   = 1'b1;
        rsv_addr = AW'(a);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        for (int p = 0; p < NR; p++) begin
            m_rd[p]  = '0;
            m_rdp[p] = 1'b0;
        end
    endtask

    // Register 0 is a constant zero: writes and reserves to it are simply never applied.
    task automatic model_edge();
        logic [DW-1:0] nm [NREGS];
        bit            np [NREGS];
        int            a;
        nm = m_mem;
        np = m_pend;
        for (int w = 0; w < NW; w++) begin
            if (wr_en[w]) begin
                a = int'(wr_addr[w*AW +: AW]);
                if (a != 0) nm[a] = wr_data[w*DW +: DW];
                np[a] = 1'b0;
            end
        end
        if (rsv_en && rsv_addr != 0) np[rsv_addr] = 1'b1;
        for (int p = 0; p < NR; p++) begin
            if (rd_en[p]) begin
                a        = int'(rd_addr[p*AW +: AW]);
                m_rd[p]  = nm[a];
                m_rdp[p] = np[a];
            end
        end
        m_mem  = nm;
        m_pend = np;
    endtask

    task automatic check_model(input string tag);
        logic [NREGS-1:0] pv;
        for (int p = 0; p < NR; p++) begin
            chk($sformatf("%s_rd_data%0d", tag, p), 64'(rd_data[p*DW +: DW]), 64'(m_rd[p]));
            chk($sformatf("%s_rd_pend%0d", tag, p), 64'(rd_pend[p]), 64'(m_rdp[p]));
        end
        for (int i = 0; i < NREGS; i++) pv[i] = m_pend[i];
        chk($sformatf("%s_pend_vec", tag), 64'(pend_vec), 64'(pv));
    endtask

    // One rising edge. The model advances and both sides are compared 1 ns later.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_model(tag);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: read addresses 0, 5 and 63 just after reset
        set_rd(0, 0);
        set_rd(1, 5);
        set_rd(2, 63);
        cycle("t1");
        chk("t1_data_all", 64'(rd_data), 64'd0);
        chk("t1_pend_all", 64'(rd_pend), 64'd0);
        chk("t1_pend_vec", 64'(pend_vec), 64'd0);
        idle();

        // 2: write r5 and read it on the same edge (bypass)
        set_wr(0, 5, 32'hDEAD_BEEF);
        set_rd(0, 5);
        cycle("t2");
        chk("t2_bypass", 64'(rd_data[0 +: DW]), 64'hDEAD_BEEF);
        idle();

        // 3: both ports write r9; port 1 wins in the bypass and in storage
        set_wr(0, 9, 32'h11);
        set_wr(1, 9, 32'h22);
        set_rd(1, 9);
        cycle("t3a");
        chk("t3_bypass_p1", 64'(rd_data[DW +: DW]), 64'h22);
        idle();
        set_rd(2, 9);
        cycle("t3b");
        chk("t3_stored_p1", 64'(rd_data[2*DW +: DW]), 64'h22);
        idle();

        // 4: writes and reserves to r0 are dropped
        set_wr(1, 0, 32'hFFFF_FFFF);
        set_rsv(0);
        set_rd(0, 0);
        cycle("t4a");
        chk("t4_r0_bypass", 64'(rd_data[0 +: DW]), 64'd0);
        idle();
        set_rd(0, 0);
        cycle("t4b");
        chk("t4_r0_read", 64'(rd_data[0 +: DW]), 64'd0);
        chk("t4_r0_pend", 64'(pend_vec[0]), 64'd0);
        idle();

        // 5: scoreboard set, clear, and reserve winning over a write
        set_rsv(7);
        cycle("t5a");
        chk("t5_rsv_vec", 64'(pend_vec[7]), 64'd1);
        idle();
        set_rd(1, 7);
        cycle("t5b");
        chk("t5_rd_pend", 64'(rd_pend[1]), 64'd1);
        idle();
        set_wr(0, 7, 32'h42);
        cycle("t5c");
        chk("t5_clear", 64'(pend_vec[7]), 64'd0);
        idle();
        set_wr(1, 7, 32'h42);
        set_rsv(7);
        set_rd(2, 7);
        cycle("t5d");
        chk("t5_rsv_wins", 64'(pend_vec[7]), 64'd1);
        chk("t5_rsv_rdpend", 64'(rd_pend[2]), 64'd1);
        chk("t5_rsv_data", 64'(rd_data[2*DW +: DW]), 64'h42);
        idle();

        // 6: reset asserted between edges clears the outputs at once
        set_wr(0, 3, 32'h1234);
        set_rd(0, 3);
        cycle("t6a");
        chk("t6_pre", 64'(rd_data[0 +: DW]), 64'h1234);
        idle();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("t6_async_data", 64'(rd_data), 64'd0);
        chk("t6_async_pend", 64'(rd_pend), 64'd0);
        chk("t6_async_vec", 64'(pend_vec), 64'd0);
        cycle("t6_hold");
        @(negedge clk);
        rst = 1'b0;
        set_rd(1, 3);
        cycle("t6b");
        chk("t6_r3_lost", 64'(rd_data[DW +: DW]), 64'd0);
        idle();

        // Randomized traffic. A narrow address window makes collisions frequent.
        for (int n = 0; n < 400; n++) begin
            int hi;
            idle();
            hi = ($urandom_range(0, 1) == 0) ? 7 : 63;
            for (int w = 0; w < NW; w++)
                if ($urandom_range(0, 9) < 5) set_wr(w, int'($urandom_range(0, hi)), $urandom);
            for (int p = 0; p < NR; p++)
                if ($urandom_range(0, 9) < 6) set_rd(p, int'($urandom_range(0, hi)));
            if ($urandom_range(0, 9) < 3) set_rsv(int'($urandom_range(0, hi)));
            cycle("rand");
        end

        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
